// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file writeback arbiter between the main pipeline and a mul/div unit
//
// Ports:
//   CLK           in   1   rising-edge clock
//   RESET         in   1   asynchronous active-low reset
//   PIPE_VALID    in   1   pipeline writeback result valid
//   PIPE_RD       in   5   pipeline destination register
//   PIPE_DATA     in  32   pipeline result
//   MD_VALID      in   1   mul/div result valid
//   MD_RD         in   5   mul/div destination register
//   MD_DATA       in  32   mul/div result
//   MD_READY      out  1   arbiter can accept a mul/div result
//   WRITE_ENABLE  out  1   register-file write enable (registered)
//   WRITE_ADDRESS out  5   register-file write address (registered)
//   WRITE_DATA    out 32   register-file write data (registered)
//   PENDING_MASK  out 32   one bit per rd currently held in the FIFO
//   STARVE        out  1   FIFO head has been blocked for STARVE_LIMIT cycles
//
// The pipeline has no backpressure and always wins the write port. Mul/div
// results are parked in a 2-entry FIFO and drained on cycles the pipeline
// leaves free.

module wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PIPE_VALID,
  input  logic [4:0]  PIPE_RD,
  input  logic [31:0] PIPE_DATA,
  input  logic        MD_VALID,
  input  logic [4:0]  MD_RD,
  input  logic [31:0] MD_DATA,
  output logic        MD_READY,
  output logic        WRITE_ENABLE,
  output logic [4:0]  WRITE_ADDRESS,
  output logic [31:0] WRITE_DATA,
  output logic [31:0] PENDING_MASK,
  output logic        STARVE
);

  localparam int WW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [WW-1:0] LIMIT_W = WW'(STARVE_LIMIT);

  // FIFO storage and control
  logic [4:0]    rd_mem_q   [2];
  logic [31:0]   data_mem_q [2];
  logic [4:0]    rd_mem_d   [2];
  logic [31:0]   data_mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q,  count_d;
  logic [WW-1:0] wait_q,   wait_d;

  // Write port registers
  logic          we_q,   we_d;
  logic [4:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic pipe_live;
  logic md_accept;
  logic push;
  logic pop;
  logic fifo_empty;
  logic rd_ptr_other;

  assign fifo_empty   = (count_q == 2'd0);
  assign pipe_live    = PIPE_VALID && (PIPE_RD != 5'd0);
  assign MD_READY     = (count_q < 2'd2) && RESET;
  assign md_accept    = MD_VALID && MD_READY;
  // rd 0 results are handshaken so the mul/div unit retires them, but never stored
  assign push         = md_accept && (MD_RD != 5'd0);
  // Pop decision uses the pre-edge count, so a fresh push is never bypassed
  assign pop          = !pipe_live && !fifo_empty;
  assign rd_ptr_other = ~rd_ptr_q;

  always_comb begin
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (pipe_live) begin
      we_d    = 1'b1;
      addr_d  = PIPE_RD;
      wdata_d = PIPE_DATA;
    end else if (!fifo_empty) begin
      we_d    = 1'b1;
      addr_d  = rd_mem_q[rd_ptr_q];
      wdata_d = data_mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (push) begin
      rd_mem_d[wr_ptr_q]   = MD_RD;
      data_mem_d[wr_ptr_q] = MD_DATA;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Wait counter: counts edges where the head is held off by the pipeline
  always_comb begin
    wait_d = wait_q;
    if (pop || fifo_empty) begin
      wait_d = '0;
    end else if (pipe_live && (wait_q != LIMIT_W)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_mem_q[0]   <= '0;
      rd_mem_q[1]   <= '0;
      data_mem_q[0] <= '0;
      data_mem_q[1] <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      wait_q        <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
    end else begin
      rd_mem_q      <= rd_mem_d;
      data_mem_q    <= data_mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      wait_q        <= wait_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
    end
  end

  // Mask is built from registered FIFO state only; duplicate rds simply OR
  // together, so the bit stays up until the last matching entry drains.
  always_comb begin
    PENDING_MASK = '0;
    if (count_q != 2'd0) begin
      PENDING_MASK[rd_mem_q[rd_ptr_q]] = 1'b1;
    end
    if (count_q == 2'd2) begin
      PENDING_MASK[rd_mem_q[rd_ptr_other]] = 1'b1;
    end
    PENDING_MASK[0] = 1'b0;
  end

  assign STARVE        = (wait_q == LIMIT_W);
  assign WRITE_ENABLE  = we_q;
  assign WRITE_ADDRESS = addr_q;
  assign WRITE_DATA    = wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter with a queue-based reference model

module tb_wb_arbiter;

  localparam int LIMIT = 4;

  logic        CLK;
  logic        RESET;
  logic        PIPE_VALID;
  logic [4:0]  PIPE_RD;
  logic [31:0] PIPE_DATA;
  logic        MD_VALID;
  logic [4:0]  MD_RD;
  logic [31:0] MD_DATA;
  logic        MD_READY;
  logic        WRITE_ENABLE;
  logic [4:0]  WRITE_ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] PENDING_MASK;
  logic        STARVE;

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .PIPE_VALID    (PIPE_VALID),
    .PIPE_RD       (PIPE_RD),
    .PIPE_DATA     (PIPE_DATA),
    .MD_VALID      (MD_VALID),
    .MD_RD         (MD_RD),
    .MD_DATA       (MD_DATA),
    .MD_READY      (MD_READY),
    .WRITE_ENABLE  (WRITE_ENABLE),
    .WRITE_ADDRESS (WRITE_ADDRESS),
    .WRITE_DATA    (WRITE_DATA),
    .PENDING_MASK  (PENDING_MASK),
    .STARVE        (STARVE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          wait_cnt;
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (q[i]) m[q[i].rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".we"},    {31'd0, WRITE_ENABLE}, {31'd0, exp_we});
    chk({tag, ".addr"},  {27'd0, WRITE_ADDRESS}, {27'd0, exp_addr});
    chk({tag, ".data"},  WRITE_DATA, exp_data);
    chk({tag, ".mask"},  PENDING_MASK, model_mask());
    chk({tag, ".starve"}, {31'd0, STARVE}, {31'd0, (wait_cnt == LIMIT)});
    chk({tag, ".ready"}, {31'd0, MD_READY}, {31'd0, (q.size() < 2)});
  endtask

  // One clock cycle: drive at negedge, update the model at the edge, check after it.
  task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                      input string tag);
    int  size_pre;
    logic ready;
    logic live;
    logic popped;
    ent_t e;
    @(negedge CLK);
    PIPE_VALID = pv; PIPE_RD = prd; PIPE_DATA = pd;
    MD_VALID = mv;   MD_RD = mrd;   MD_DATA = md;
    #1;
    size_pre = q.size();
    ready    = (size_pre < 2);
    chk({tag, ".ready_pre"}, {31'd0, MD_READY}, {31'd0, ready});
    live   = pv && (prd != 0);
    popped = 1'b0;
    if (live) begin
      exp_we = 1'b1; exp_addr = prd; exp_data = pd;
    end else if (size_pre > 0) begin
      e = q.pop_front();
      exp_we = 1'b1; exp_addr = e.rd; exp_data = e.data;
      popped = 1'b1;
    end else begin
      exp_we = 1'b0;
    end
    if (popped || size_pre == 0) wait_cnt = 0;
    else if (live && wait_cnt < LIMIT) wait_cnt++;
    if (mv && ready && mrd != 0) begin
      e.rd = mrd; e.data = md;
      q.push_back(e);
    end
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, tag);
  endtask

  // Reset pulse placed between edges; outputs must clear asynchronously.
  task automatic do_reset(input string tag);
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    q.delete();
    wait_cnt = 0;
    exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    chk({tag, ".rst_we"},    {31'd0, WRITE_ENABLE}, 32'd0);
    chk({tag, ".rst_addr"},  {27'd0, WRITE_ADDRESS}, 32'd0);
    chk({tag, ".rst_data"},  WRITE_DATA, 32'd0);
    chk({tag, ".rst_mask"},  PENDING_MASK, 32'd0);
    chk({tag, ".rst_starve"}, {31'd0, STARVE}, 32'd0);
    chk({tag, ".rst_ready"}, {31'd0, MD_READY}, 32'd0);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    chk({tag, ".rel_ready"}, {31'd0, MD_READY}, 32'd1);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    wait_cnt = 0;
    exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    RESET = 1'b0;
    PIPE_VALID = 1'b0; PIPE_RD = '0; PIPE_DATA = '0;
    MD_VALID = 1'b0;   MD_RD = '0;   MD_DATA = '0;

    // Reset state
    #3;
    chk("reset.we",     {31'd0, WRITE_ENABLE}, 32'd0);
    chk("reset.mask",   PENDING_MASK, 32'd0);
    chk("reset.ready",  {31'd0, MD_READY}, 32'd0);
    chk("reset.starve", {31'd0, STARVE}, 32'd0);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    chk("release.ready", {31'd0, MD_READY}, 32'd1);

    // Pipeline only
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, "pipe5");
    chk("pipe5.addr_k", {27'd0, WRITE_ADDRESS}, 32'd5);
    chk("pipe5.data_k", WRITE_DATA, 32'hDEADBEEF);
    step(1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'd0, "pipe_rd0");
    chk("pipe_rd0.we_k", {31'd0, WRITE_ENABLE}, 32'd0);

    // Mul/div only
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12, "md7_push");
    chk("md7.mask_k", PENDING_MASK, 32'h80);
    idle("md7_pop");
    chk("md7.addr_k", {27'd0, WRITE_ADDRESS}, 32'd7);
    chk("md7.mask0_k", PENDING_MASK, 32'd0);

    // Conflict and starvation
    step(1'b1, 5'd9, 32'h900, 1'b1, 5'd3, 32'h33, "conf0");
    for (int i = 0; i < 4; i++) step(1'b1, 5'd9, 32'h901 + i, 1'b0, 5'd0, 32'd0, "conf");
    chk("conf.starve_k", {31'd0, STARVE}, 32'd1);
    idle("conf_free");
    chk("conf_free.addr_k", {27'd0, WRITE_ADDRESS}, 32'd3);
    chk("conf_free.starve_k", {31'd0, STARVE}, 32'd0);

    // Full FIFO, then order of drain
    step(1'b1, 5'd10, 32'hA0, 1'b1, 5'd1, 32'h1, "full_p1");
    step(1'b1, 5'd10, 32'hA1, 1'b1, 5'd2, 32'h2, "full_p2");
    chk("full.ready_k", {31'd0, MD_READY}, 32'd0);
    step(1'b1, 5'd10, 32'hA2, 1'b1, 5'd4, 32'h4, "full_ignored");
    idle("full_pop1");
    chk("full_pop1.addr_k", {27'd0, WRITE_ADDRESS}, 32'd1);
    chk("full_pop1.ready_k", {31'd0, MD_READY}, 32'd1);
    idle("full_pop2");
    chk("full_pop2.addr_k", {27'd0, WRITE_ADDRESS}, 32'd2);

    // Duplicate rd held twice
    step(1'b1, 5'd11, 32'hB0, 1'b1, 5'd6, 32'h61, "dup1");
    step(1'b1, 5'd11, 32'hB1, 1'b1, 5'd6, 32'h62, "dup2");
    idle("dup_pop1");
    chk("dup_pop1.mask_k", PENDING_MASK, 32'h40);
    idle("dup_pop2");
    chk("dup_pop2.data_k", WRITE_DATA, 32'h62);

    // Reset mid-operation with a full FIFO
    step(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD, "rst_fill1");
    step(1'b1, 5'd12, 32'hC1, 1'b1, 5'd14, 32'hE, "rst_fill2");
    do_reset("midrst");
    idle("after_rst");
    chk("after_rst.we_k", {31'd0, WRITE_ENABLE}, 32'd0);

    // Discarded rd 0 handshake
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, "discard");
    chk("discard.mask_k", PENDING_MASK, 32'd0);
    idle("discard_next");
    chk("discard_next.we_k", {31'd0, WRITE_ENABLE}, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic        pv;
      logic        mv;
      logic [4:0]  prd;
      logic [4:0]  mrd;
      pv  = ($urandom_range(0, 99) < 55);
      mv  = ($urandom_range(0, 99) < 50);
      prd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      mrd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      if (n % 150 == 149) do_reset("rand_rst");
      step(pv, prd, $urandom, mv, mrd, $urandom, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
